// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Programmable LEN-symbol pattern detector over a SYM_W-bit
//             symbol stream. Produces a registered per-match pulse, a
//             clearable sticky flag, a saturating match counter and the
//             current history fill level.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detector_param #(
  parameter int                     SYM_W   = 2,
  parameter int                     LEN     = 3,
  parameter int                     CNT_W   = 8,
  parameter logic [LEN*SYM_W-1:0]   PAT_RST = 6'b111001
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             sym,
  input  logic                         cfg_load,
  input  logic [LEN*SYM_W-1:0]         pat_in,
  input  logic                         overlap,
  input  logic                         clr_found,
  output logic                         match,
  output logic                         found,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(LEN+1)-1:0]     fill
);

  localparam int                 PW        = LEN * SYM_W;
  localparam int                 FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  // Slot 0 sits in the LSBs for both pattern and history, so a full history
  // matches when the two packed vectors are equal.
  logic [PW-1:0]      pat_q,   pat_d;
  logic [PW-1:0]      hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic               match_q, match_d;
  logic               found_q, found_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [PW-1:0]      hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  // Next-state computation: shift/compare, overlap handling, flag and counter.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;

    // Oldest symbol (slot 0, LSBs) falls off; the new one enters slot LEN-1.
    hist_shift = {sym, hist_q[PW-1:SYM_W]};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    hit        = in_valid && !cfg_load && (fill_inc == FILL_FULL) &&
                 (hist_shift == pat_q);

    if (cfg_load) begin
      // Reprogramming restarts detection; any symbol this cycle is dropped.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d  = hist_shift;
      // Non-overlap mode only needs fill cleared: stale history is then
      // ignored until LEN fresh symbols have arrived.
      fill_d  = (hit && !overlap) ? '0 : fill_inc;
      match_d = hit;
    end

    // A new hit takes priority over a simultaneous clear request.
    found_d = hit | (found_q & ~clr_found);

    if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      found_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign found     = found_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Self-checking bench for seq_detector_param. A reference model
//             predicts every cycle's outputs into a queue; a monitor pops and
//             compares after each clock edge. Scenario tasks add targeted
//             checks on top.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, in_valid, cfg_load, overlap, clr_found;
  logic [1:0] sym;
  logic [5:0] pat_in;

  logic       match,  found;
  logic [7:0] match_cnt;
  logic [1:0] fill;
  logic       match2, found2;
  logic [1:0] match_cnt2;
  logic [1:0] fill2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       m;
    logic       f;
    logic [7:0] c;
    logic [1:0] c2;
    logic [1:0] fl;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] m_pat;
  logic [1:0] m_hist[$];
  logic       m_found;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .cfg_load(cfg_load), .pat_in(pat_in), .overlap(overlap),
    .clr_found(clr_found), .match(match), .found(found),
    .match_cnt(match_cnt), .fill(fill)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sym(sym),
    .cfg_load(cfg_load), .pat_in(pat_in), .overlap(overlap),
    .clr_found(clr_found), .match(match2), .found(found2),
    .match_cnt(match_cnt2), .fill(fill2)
  );

  // Monitor: compare DUT outputs with the predicted values after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (match !== e.m) begin
        failures++;
        $display("FAIL mon_match t=%0t got=%0b exp=%0b", $time, match, e.m);
      end
      checks++;
      if (found !== e.f) begin
        failures++;
        $display("FAIL mon_found t=%0t got=%0b exp=%0b", $time, found, e.f);
      end
      checks++;
      if (match_cnt !== e.c) begin
        failures++;
        $display("FAIL mon_cnt t=%0t got=%0d exp=%0d", $time, match_cnt, e.c);
      end
      checks++;
      if (match_cnt2 !== e.c2) begin
        failures++;
        $display("FAIL mon_cnt2 t=%0t got=%0d exp=%0d", $time, match_cnt2, e.c2);
      end
      checks++;
      if (fill !== e.fl) begin
        failures++;
        $display("FAIL mon_fill t=%0t got=%0d exp=%0d", $time, fill, e.fl);
      end
      checks++;
      if (match2 !== e.m) begin
        failures++;
        $display("FAIL mon_match2 t=%0t got=%0b exp=%0b", $time, match2, e.m);
      end
    end
  end

  // Predict the outcome of the inputs currently applied, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic hit;
    hit = 1'b0;
    if (reset) begin
      m_pat   = 6'b111001;
      m_hist.delete();
      m_found = 1'b0;
      m_cnt   = '0;
      m_cnt2  = '0;
    end else if (cfg_load) begin
      m_pat = pat_in;
      m_hist.delete();
      m_found = m_found & ~clr_found;
    end else begin
      if (in_valid) begin
        m_hist.push_back(sym);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        if (m_hist.size() == 3) begin
          hit = 1'b1;
          for (int i = 0; i < 3; i++)
            if (m_hist[i] !== m_pat[i*2 +: 2]) hit = 1'b0;
        end
        if (hit && !overlap) m_hist.delete();
      end
      m_found = hit | (m_found & ~clr_found);
      if (hit && m_cnt  != 8'hFF) m_cnt  = m_cnt + 8'd1;
      if (hit && m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
    end
    e.m  = hit;
    e.f  = m_found;
    e.c  = m_cnt;
    e.c2 = m_cnt2;
    e.fl = 2'(m_hist.size());
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic put(input logic v, input logic [1:0] s);
    in_valid = v;
    sym      = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [5:0] p);
    pat_in   = p;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (match !== 1'b0 || found !== 1'b0 || match_cnt !== 8'd0 || fill !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got m=%0b f=%0b c=%0d fl=%0d exp all 0",
               match, found, match_cnt, fill);
    end
  endtask

  task automatic test_basic();
    do_reset();
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    checks++;
    if (match !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got=%0b exp=0", match);
    end
    put(1'b1, 2'b11);
    checks++;
    if (match !== 1'b1 || found !== 1'b1 || match_cnt !== 8'd1 || fill !== 2'd3) begin
      failures++;
      $display("FAIL basic_hit got m=%0b f=%0b c=%0d fl=%0d exp 1 1 1 3",
               match, found, match_cnt, fill);
    end
    put(1'b0, 2'b00);
    checks++;
    if (match !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse got=%0b exp=0", match);
    end
  endtask

  task automatic test_gaps();
    logic [1:0] s1[4];
    int         hits;
    s1   = '{2'b01, 2'b00, 2'b10, 2'b11};
    hits = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(1'b1, s1[i]);
      if (match === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL nomatch_hits got=%0d exp=0", hits);
    end
    put(1'b1, 2'b01);
    put(1'b0, 2'b11);
    put(1'b0, 2'b10);
    put(1'b1, 2'b10);
    put(1'b1, 2'b11);
    checks++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL gap_hit got m=%0b c=%0d exp m=1 c=1", match, match_cnt);
    end
  endtask

  task automatic test_overlap(input logic ov, input logic [4:0] exp_mask,
                              input logic [1:0] exp_fill);
    logic [4:0] mask;
    mask = '0;
    do_reset();
    overlap = ov;
    load(6'b010101);
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 2'b01);
      mask[i] = match;
    end
    checks++;
    if (mask !== exp_mask) begin
      failures++;
      $display("FAIL overlap%0b_mask got=%b exp=%b", ov, mask, exp_mask);
    end
    checks++;
    if (fill !== exp_fill) begin
      failures++;
      $display("FAIL overlap%0b_fill got=%0d exp=%0d", ov, fill, exp_fill);
    end
    overlap = 1'b1;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c2[5];
    int         n;
    exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n = 0;
    do_reset();
    load(6'b010101);
    for (int i = 0; i < 7; i++) begin
      put(1'b1, 2'b01);
      if (match2 === 1'b1 && n < 5) begin
        checks++;
        if (match_cnt2 !== exp_c2[n]) begin
          failures++;
          $display("FAIL sat_cnt2_%0d got=%0d exp=%0d", n, match_cnt2, exp_c2[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5 || match_cnt !== 8'd5) begin
      failures++;
      $display("FAIL sat_total got pulses=%0d cnt=%0d exp 5 5", n, match_cnt);
    end
  endtask

  task automatic test_clr_found();
    do_reset();
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    clr_found = 1'b1;
    put(1'b1, 2'b11);
    clr_found = 1'b0;
    checks++;
    if (found !== 1'b1) begin
      failures++;
      $display("FAIL clr_same_cycle got=%0b exp=1", found);
    end
    clr_found = 1'b1;
    put(1'b0, 2'b00);
    clr_found = 1'b0;
    checks++;
    if (found !== 1'b0) begin
      failures++;
      $display("FAIL clr_alone got=%0b exp=0", found);
    end
  endtask

  task automatic test_cfg_drop();
    do_reset();
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    pat_in   = 6'b111001;
    cfg_load = 1'b1;
    put(1'b1, 2'b11);
    cfg_load = 1'b0;
    checks++;
    if (match !== 1'b0 || fill !== 2'd0 || match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cfg_drop got m=%0b fl=%0d c=%0d exp 0 0 0", match, fill, match_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    load(6'b010101);
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    do_reset();
    put(1'b1, 2'b11);
    checks++;
    if (match !== 1'b0 || fill !== 2'd1) begin
      failures++;
      $display("FAIL midrst_nomatch got m=%0b fl=%0d exp m=0 fl=1", match, fill);
    end
    // The reset pattern, not the loaded one, must be active again.
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    put(1'b1, 2'b11);
    checks++;
    if (match !== 1'b1) begin
      failures++;
      $display("FAIL midrst_patrst got=%0b exp=1", match);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    cfg_load  = 1'b0;
    overlap   = 1'b1;
    clr_found = 1'b0;
    sym       = 2'b00;
    pat_in    = 6'b000000;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_overlap(1'b1, 5'b11100, 2'd3);
    test_overlap(1'b0, 5'b00100, 2'd2);
    test_saturate();
    test_clr_found();
    test_cfg_drop();
    test_mid_reset();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=expired exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
